kyber_fntt_host_seq: RTL and testbench
======================================

Name: kyber_fntt_host_seq

Overview:
- Host-side initiator for the KyberHPM1PE accelerator. It drives the accelerator's load, start and read protocol for one forward NTT of polynomial A or B.
- It owns a 256x12 source buffer, which the host fills, and a 256x12 result buffer, which the host reads back.
- It streams coefficients to the accelerator, waits for `done`, and captures the accelerator's bit-swapped output order (0,2,1,3,...) back into natural order.
- It sits between the system bus glue and the accelerator core, replacing bench-style stimulus in silicon.

Parameters:
- START_GAP, 2: idle cycles between the last streamed coefficient and the `start_fntt` pulse.
- READ_GAP, 2: idle cycles between the read pulse and the first valid `acc_dout` sample.
- TIMEOUT_CYCLES, 4096: watchdog limit while waiting for `acc_done`. Used only when `KYBER_SEQ_TIMEOUT_EN` is defined.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- wr_en  in  1  source buffer write strobe
- wr_addr  in  8  source buffer address
- wr_data  in  12  source coefficient
- rd_addr  in  8  result buffer address
- rd_data  out  12  result coefficient, 1-cycle read latency
- cmd_valid  in  1  start request
- cmd_sel  in  1  0 = polynomial A, 1 = polynomial B
- cmd_ready  out  1  high when IDLE
- busy  out  1  high in any state other than IDLE
- seq_done  out  1  one-cycle pulse when a sequence completes
- err  out  1  sticky watchdog error, cleared by the next accepted command
- load_a_f, load_b_f  out  1 each  accelerator load pulses
- start_fntt, start_ab  out  1 each  accelerator start pulse and A/B select
- read_a, read_b  out  1 each  accelerator read pulses
- acc_din  out  12  coefficient to the accelerator
- acc_dout  in  12  coefficient from the accelerator
- acc_done  in  1  accelerator done, level signal

Behaviour:
- Reset: all outputs are 0, except `cmd_ready`=1 and `rd_data`=0. State goes to IDLE. Buffer contents are retained.
- Clock and reset: one clock, `clk`. `reset` is synchronous and active-high.
- Host writes to the source buffer are accepted only while `busy`=0; a write with `busy`=1 is ignored. Host reads of the result buffer are allowed at any time.
- Command accept: the handshake is `cmd_valid` & `cmd_ready`. On accept, `cmd_sel` is latched and `err` is cleared.
- State sequence:
  - IDLE to LOAD: one cycle with `load_a_f` or `load_b_f`=1, chosen by the latched select.
  - STREAM: 256 cycles. `acc_din` = src[0..255] on consecutive cycles, src[0] on the cycle immediately after LOAD. The source buffer is prefetched during LOAD to hide read latency. `acc_din` returns to 0 afterwards.
  - GAP: START_GAP cycles.
  - START: one cycle with `start_fntt`=1 and `start_ab`=select.
  - ARM: 2 cycles in which `acc_done` is ignored.
  - WAIT: remains until the first cycle `acc_done`=1.
  - POST: 1 cycle.
  - RDP: one cycle with `read_a` or `read_b`=1.
  - RGAP: READ_GAP cycles.
  - CAPTURE: 256 cycles sampling `acc_dout`.
  - FIN: `seq_done`=1 for one cycle, then IDLE.
- Reorder rule: capture sample j (0..255) is written to result[{j[7:2], j[0], j[1]}], i.e. bits 1:0 are swapped. For example j=1 goes to index 2 and j=2 goes to index 1.
- Counters: 8-bit sample counters. The terminal count is 255; no wrap beyond one pass.
- Simultaneous events:
  - `cmd_valid` while busy is ignored, with no queueing.
  - A host `rd_addr` read during CAPTURE returns the pre-write value for the location being written that cycle (read-first).
  - `acc_done` already high in ARM is not sampled until WAIT.
- Reset mid-operation: all pulses and `acc_din` are 0 on the cycle after reset is sampled. `busy`=0, and no `seq_done` is issued.

Optional Feature:
- Macro `KYBER_SEQ_TIMEOUT_EN`.
- Defined: a counter runs in WAIT. If `acc_done` is not seen within TIMEOUT_CYCLES, `err`=1 (sticky) and the FSM jumps to FIN, issuing the `seq_done` pulse. No read pulse is issued and the result buffer is unchanged.
- Undefined: no counter; WAIT waits indefinitely and `err` is tied to 0.

Test Plan:
- Fill src[i]=i, command with `cmd_sel`=0 → `load_a_f` high 1 cycle; `acc_din`=0x000..0x0FF on the next 256 cycles; `start_fntt`=1 with `start_ab`=0 exactly START_GAP+1 cycles after `acc_din`=0x0FF.
- Accelerator model raises `acc_done` 50 cycles after start, then drives `acc_dout`=sample count starting READ_GAP cycles after `read_a` → result[0]=0, result[1]=2, result[2]=1, result[3]=3, result[254]=253; `seq_done` pulses once.
- `cmd_sel`=1 → `load_b_f`, `start_ab`=1 coincident with `start_fntt`, `read_b` pulse; `load_a_f`/`read_a` never asserted.
- `cmd_valid` and `wr_en` (addr 5, data 0xABC) during STREAM → `cmd_ready`=0, src[5] unchanged, and the in-flight stream is unaffected.
- Assert `reset` at STREAM sample 100 → next cycle all control outputs and `acc_din`=0, `busy`=0, `cmd_ready`=1; a new command restarts from LOAD.
- With `KYBER_SEQ_TIMEOUT_EN` and TIMEOUT_CYCLES=64, `acc_done` held 0 → `err`=1 and `seq_done` pulse 64 cycles into WAIT; no read pulse; the next accepted command clears `err`.

Source files
------------

// File: rtl/kyber_fntt_host_seq.sv
// -----------------------------------------------------------------------------
// kyber_fntt_host_seq
//
// Host-side initiator for the KyberHPM1PE accelerator. Runs one forward NTT of
// polynomial A or B: loads 256 coefficients from a host-filled source buffer,
// pulses start, waits for done, issues the read pulse and captures the
// accelerator's bit-swapped output order (0,2,1,3,...) back into natural order
// in a result buffer the host can read at any time.
//
// Sequence: IDLE -> LOAD -> STREAM(256) -> GAP(START_GAP) -> START -> ARM(2)
//           -> WAIT -> POST -> RDP -> RGAP(READ_GAP) -> CAPTURE(256) -> FIN
//
// Ports
//   clk, reset            : single clock, synchronous active-high reset
//   wr_en/wr_addr/wr_data : source buffer write port (ignored while busy)
//   rd_addr/rd_data       : result buffer read port, 1-cycle latency, read-first
//   cmd_valid/cmd_sel     : start request, 0 = polynomial A, 1 = polynomial B
//   cmd_ready, busy       : ready only in IDLE, busy everywhere else
//   seq_done              : one-cycle pulse when a sequence completes
//   err                   : sticky watchdog error, cleared by the next command
//   load_a_f, load_b_f    : accelerator load pulses
//   start_fntt, start_ab  : accelerator start pulse and A/B select
//   read_a, read_b        : accelerator read pulses
//   acc_din, acc_dout     : coefficient to / from the accelerator
//   acc_done              : accelerator done level
//
// Optional feature: define KYBER_SEQ_TIMEOUT_EN to enable a WAIT watchdog of
// TIMEOUT_CYCLES cycles. Without it WAIT is unbounded and err is tied to 0.
// -----------------------------------------------------------------------------
module kyber_fntt_host_seq #(
    parameter int unsigned START_GAP      = 2,
    parameter int unsigned READ_GAP       = 2,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_en,
    input  logic [7:0]  wr_addr,
    input  logic [11:0] wr_data,
    input  logic [7:0]  rd_addr,
    output logic [11:0] rd_data,
    input  logic        cmd_valid,
    input  logic        cmd_sel,
    output logic        cmd_ready,
    output logic        busy,
    output logic        seq_done,
    output logic        err,
    output logic        load_a_f,
    output logic        load_b_f,
    output logic        start_fntt,
    output logic        start_ab,
    output logic        read_a,
    output logic        read_b,
    output logic [11:0] acc_din,
    input  logic [11:0] acc_dout,
    input  logic        acc_done
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_LOAD,
        S_STREAM,
        S_GAP,
        S_START,
        S_ARM,
        S_WAIT,
        S_POST,
        S_RDP,
        S_RGAP,
        S_CAPTURE,
        S_FIN
    } state_e;

    localparam logic [7:0] LAST_SAMPLE = 8'd255;
    localparam logic [7:0] ARM_LAST    = 8'd1;
    localparam logic [7:0] START_LAST  = 8'(START_GAP - 1);
    localparam logic [7:0] READ_LAST   = 8'(READ_GAP - 1);

    logic [11:0] src_mem [256];
    logic [11:0] res_mem [256];

    state_e      state_q;
    logic [7:0]  cnt_q;
    logic        sel_q;
    logic        cmd_ready_q;
    logic        busy_q;
    logic        seq_done_q;
    logic        load_a_q;
    logic        load_b_q;
    logic        start_fntt_q;
    logic        start_ab_q;
    logic        read_a_q;
    logic        read_b_q;
    logic [11:0] acc_din_q;
    logic [11:0] rd_data_q;

`ifdef KYBER_SEQ_TIMEOUT_EN
    localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    logic [TMO_W-1:0] tmo_q;
    logic             err_q;
`endif

    // Capture sample j lands at j with bits 1:0 swapped (undoes 0,2,1,3 order).
    logic [7:0] cap_addr_d;
    logic       cap_we_d;

    assign cap_addr_d = {cnt_q[7:2], cnt_q[0], cnt_q[1]};
    assign cap_we_d   = (state_q == S_CAPTURE) && !reset;

    // NOTE: buffers are plain storage with no reset; a sequence always
    // overwrites every result location, so clearing them would only cost logic.
    always_ff @(posedge clk) begin
        if (wr_en && !busy_q) begin
            src_mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (cap_we_d) begin
            res_mem[cap_addr_d] <= acc_dout;
        end
    end

    // Same-edge read of the location being captured returns the old contents,
    // since both sides sample res_mem before the edge updates it.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data_q <= 12'd0;
        end else begin
            rd_data_q <= res_mem[rd_addr];
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: every pulse defaults low here, so each branch below only states
        // the cycle it fires on; the defaults are non-blocking like all state.
        load_a_q     <= 1'b0;
        load_b_q     <= 1'b0;
        start_fntt_q <= 1'b0;
        start_ab_q   <= 1'b0;
        read_a_q     <= 1'b0;
        read_b_q     <= 1'b0;
        seq_done_q   <= 1'b0;

        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= 8'd0;
            sel_q       <= 1'b0;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            acc_din_q   <= 12'd0;
`ifdef KYBER_SEQ_TIMEOUT_EN
            tmo_q       <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (cmd_valid && cmd_ready_q) begin
                        sel_q       <= cmd_sel;
                        load_a_q    <= !cmd_sel;
                        load_b_q    <= cmd_sel;
                        cmd_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        state_q     <= S_LOAD;
`ifdef KYBER_SEQ_TIMEOUT_EN
                        err_q       <= 1'b0;
`endif
                    end
                end

                // Prefetch src[0] so it is on acc_din the cycle after LOAD.
                S_LOAD: begin
                    acc_din_q <= src_mem[8'd0];
                    cnt_q     <= 8'd0;
                    state_q   <= S_STREAM;
                end

                // cnt_q is the index currently presented on acc_din.
                S_STREAM: begin
                    if (cnt_q == LAST_SAMPLE) begin
                        acc_din_q <= 12'd0;
                        cnt_q     <= 8'd0;
                        if (START_GAP == 0) begin
                            start_fntt_q <= 1'b1;
                            start_ab_q   <= sel_q;
                            state_q      <= S_START;
                        end else begin
                            state_q <= S_GAP;
                        end
                    end else begin
                        acc_din_q <= src_mem[cnt_q + 8'd1];
                        cnt_q     <= cnt_q + 8'd1;
                    end
                end

                S_GAP: begin
                    if (cnt_q == START_LAST) begin
                        cnt_q        <= 8'd0;
                        start_fntt_q <= 1'b1;
                        start_ab_q   <= sel_q;
                        state_q      <= S_START;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end

                S_START: begin
                    cnt_q   <= 8'd0;
                    state_q <= S_ARM;
                end

                // acc_done may still be high from a previous run; ignore it here.
                S_ARM: begin
                    if (cnt_q == ARM_LAST) begin
                        cnt_q   <= 8'd0;
                        state_q <= S_WAIT;
`ifdef KYBER_SEQ_TIMEOUT_EN
                        tmo_q   <= '0;
`endif
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end

                S_WAIT: begin
                    if (acc_done) begin
                        state_q <= S_POST;
                    end
`ifdef KYBER_SEQ_TIMEOUT_EN
                    else if (tmo_q == TMO_LAST) begin
                        err_q      <= 1'b1;
                        seq_done_q <= 1'b1;
                        state_q    <= S_FIN;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
`endif
                end

                S_POST: begin
                    read_a_q <= !sel_q;
                    read_b_q <= sel_q;
                    state_q  <= S_RDP;
                end

                S_RDP: begin
                    cnt_q   <= 8'd0;
                    state_q <= (READ_GAP == 0) ? S_CAPTURE : S_RGAP;
                end

                S_RGAP: begin
                    if (cnt_q == READ_LAST) begin
                        cnt_q   <= 8'd0;
                        state_q <= S_CAPTURE;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end

                S_CAPTURE: begin
                    if (cnt_q == LAST_SAMPLE) begin
                        cnt_q      <= 8'd0;
                        seq_done_q <= 1'b1;
                        state_q    <= S_FIN;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end

                S_FIN: begin
                    cmd_ready_q <= 1'b1;
                    busy_q      <= 1'b0;
                    state_q     <= S_IDLE;
                end

                default: begin
                    cmd_ready_q <= 1'b1;
                    busy_q      <= 1'b0;
                    state_q     <= S_IDLE;
                end
            endcase
        end
    end

    assign rd_data    = rd_data_q;
    assign cmd_ready  = cmd_ready_q;
    assign busy       = busy_q;
    assign seq_done   = seq_done_q;
    assign load_a_f   = load_a_q;
    assign load_b_f   = load_b_q;
    assign start_fntt = start_fntt_q;
    assign start_ab   = start_ab_q;
    assign read_a     = read_a_q;
    assign read_b     = read_b_q;
    assign acc_din    = acc_din_q;

`ifdef KYBER_SEQ_TIMEOUT_EN
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_kyber_fntt_host_seq.sv
// -----------------------------------------------------------------------------
// tb_kyber_fntt_host_seq
//
// Self-checking bench for kyber_fntt_host_seq. A small accelerator model
// answers start/read, a monitor records pulse timing and the streamed
// coefficients, and a reference result buffer is built from the reorder rule.
// -----------------------------------------------------------------------------
module tb_kyber_fntt_host_seq;

    localparam int START_GAP = 2;
    localparam int READ_GAP  = 2;
`ifdef KYBER_SEQ_TIMEOUT_EN
    localparam int TMO = 64;
`else
    localparam int TMO = 4096;
`endif

    logic        clk;
    logic        reset;
    logic        wr_en;
    logic [7:0]  wr_addr;
    logic [11:0] wr_data;
    logic [7:0]  rd_addr;
    logic [11:0] rd_data;
    logic        cmd_valid;
    logic        cmd_sel;
    logic        cmd_ready;
    logic        busy;
    logic        seq_done;
    logic        err;
    logic        load_a_f;
    logic        load_b_f;
    logic        start_fntt;
    logic        start_ab;
    logic        read_a;
    logic        read_b;
    logic [11:0] acc_din;
    logic [11:0] acc_dout;
    logic        acc_done;

    kyber_fntt_host_seq #(
        .START_GAP      (START_GAP),
        .READ_GAP       (READ_GAP),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .cmd_valid  (cmd_valid),
        .cmd_sel    (cmd_sel),
        .cmd_ready  (cmd_ready),
        .busy       (busy),
        .seq_done   (seq_done),
        .err        (err),
        .load_a_f   (load_a_f),
        .load_b_f   (load_b_f),
        .start_fntt (start_fntt),
        .start_ab   (start_ab),
        .read_a     (read_a),
        .read_b     (read_b),
        .acc_din    (acc_din),
        .acc_dout   (acc_dout),
        .acc_done   (acc_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------------------------------------------------------- checking
    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------ bench models
    logic [11:0] src_model [256];
    logic [11:0] res_model [256];
    logic [11:0] acc_vals  [256];
    int          done_dly = 0;
    int          run_id   = 0;

    function automatic int swap_idx(input int j);
        return (j & ~3) | ((j & 1) << 1) | ((j >> 1) & 1);
    endfunction

    // Accelerator model: raises done done_dly cycles after start (0 = never),
    // drops it on the read pulse, then after READ_GAP idle cycles plays
    // acc_vals[0..255] on consecutive cycles.
    initial begin : acc_model
        int mode;
        int cnt;
        int j;
        mode     = 0;
        cnt      = 0;
        j        = 0;
        acc_done = 1'b0;
        acc_dout = 12'd0;
        forever begin
            tick();
            if (reset) begin
                mode     = 0;
                acc_done = 1'b0;
                acc_dout = 12'd0;
            end else begin
                case (mode)
                    0: if (start_fntt && done_dly > 0) begin
                        cnt  = done_dly;
                        mode = 1;
                    end
                    1: begin
                        cnt--;
                        if (cnt == 0) begin
                            acc_done = 1'b1;
                            mode     = 2;
                        end
                    end
                    2: if (read_a || read_b) begin
                        acc_done = 1'b0;
                        j        = 0;
                        if (READ_GAP == 0) mode = 4;
                        else begin
                            cnt  = READ_GAP;
                            mode = 3;
                        end
                    end
                    3: begin
                        cnt--;
                        if (cnt == 0) mode = 4;
                    end
                    4: begin
                        acc_dout = acc_vals[j];
                        j++;
                        if (j == 256) mode = 5;
                    end
                    default: begin
                        acc_dout = 12'd0;
                        mode     = 0;
                    end
                endcase
            end
        end
    end

    // Monitor: per-run pulse counts, pulse cycles and stream contents.
    int m_cyc = 0;
    int m_seen_id = -1;
    int n_load_a, n_load_b, n_start, n_read_a, n_read_b, n_done;
    int cyc_load, cyc_start, cyc_read, cyc_done, start_ab_v;
    int stream_bad, din_bad, hs_bad;

    always @(posedge clk) begin
        #1;
        m_cyc++;
        if (run_id != m_seen_id) begin
            m_seen_id  = run_id;
            n_load_a   = 0;
            n_load_b   = 0;
            n_start    = 0;
            n_read_a   = 0;
            n_read_b   = 0;
            n_done     = 0;
            cyc_load   = -1;
            cyc_start  = -1;
            cyc_read   = -1;
            cyc_done   = -1;
            start_ab_v = -1;
            stream_bad = 0;
            din_bad    = 0;
            hs_bad     = 0;
        end
        if (load_a_f) n_load_a++;
        if (load_b_f) n_load_b++;
        if (load_a_f || load_b_f) cyc_load = m_cyc;
        if (start_fntt) begin
            n_start++;
            cyc_start  = m_cyc;
            start_ab_v = int'(start_ab);
        end
        if (read_a) n_read_a++;
        if (read_b) n_read_b++;
        if (read_a || read_b) cyc_read = m_cyc;
        if (seq_done) begin
            n_done++;
            cyc_done = m_cyc;
        end
        if (cmd_ready == busy) hs_bad++;
        if (cyc_load >= 0 && m_cyc > cyc_load && m_cyc <= cyc_load + 256) begin
            if (acc_din != src_model[m_cyc - cyc_load - 1]) stream_bad++;
        end else if (acc_din != 12'd0) begin
            din_bad++;
        end
    end

    // ------------------------------------------------------------ host tasks
    task automatic fill_src(input bit directed);
        for (int i = 0; i < 256; i++) begin
            wr_en   = 1'b1;
            wr_addr = 8'(i);
            wr_data = directed ? 12'(i) : 12'($urandom_range(0, 4095));
            src_model[i] = wr_data;
            tick();
        end
        wr_en = 1'b0;
    endtask

    task automatic fill_acc(input bit directed);
        for (int j = 0; j < 256; j++) begin
            acc_vals[j] = directed ? 12'(j) : 12'($urandom_range(0, 4095));
        end
    endtask

    task automatic issue(input logic sel, input string tag);
        check({tag, "_ready_before_cmd"}, int'(cmd_ready), 1);
        run_id++;
        cmd_valid = 1'b1;
        cmd_sel   = sel;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            tick();
            if (seq_done) begin
                seen = 1'b1;
                break;
            end
        end
        check({tag, "_seq_done_seen"}, int'(seen), 1);
    endtask

    task automatic readback_all(input string name);
        int bad;
        bad = 0;
        for (int a = 0; a < 256; a++) begin
            rd_addr = 8'(a);
            tick();
            if (rd_data !== res_model[a]) bad++;
        end
        check(name, bad, 0);
    endtask

    // Post-run checks for a normally completing sequence; rd_off is the
    // expected distance from start_fntt to the read pulse.
    task automatic finish_run(input logic sel, input int rd_off, input string tag);
        tick();
        tick();
        check({tag, "_load_a_cnt"}, n_load_a, sel ? 0 : 1);
        check({tag, "_load_b_cnt"}, n_load_b, sel ? 1 : 0);
        check({tag, "_start_cnt"}, n_start, 1);
        check({tag, "_start_ab"}, start_ab_v, int'(sel));
        check({tag, "_start_ofs"}, cyc_start - cyc_load, 256 + START_GAP + 1);
        check({tag, "_read_ofs"}, cyc_read - cyc_start, rd_off);
        check({tag, "_read_a_cnt"}, n_read_a, sel ? 0 : 1);
        check({tag, "_read_b_cnt"}, n_read_b, sel ? 1 : 0);
        check({tag, "_done_ofs"}, cyc_done - cyc_read, READ_GAP + 1 + 256);
        check({tag, "_done_cnt"}, n_done, 1);
        check({tag, "_stream_bad"}, stream_bad, 0);
        check({tag, "_din_idle_bad"}, din_bad, 0);
        check({tag, "_ready_busy_bad"}, hs_bad, 0);
        check({tag, "_err"}, int'(err), 0);
        for (int j = 0; j < 256; j++) res_model[swap_idx(j)] = acc_vals[j];
        readback_all({tag, "_result"});
    endtask

    // ------------------------------------------------------------ vector tables
    typedef struct {
        logic sel;
        int   dly;
        bit   directed;
        int   rd_off;
    } run_vec_t;

    typedef struct {
        int addr;
        int exp;
    } rd_vec_t;

    run_vec_t vecs [5];
    rd_vec_t  rdv  [9];

    initial begin : watchdog
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        logic [11:0] old5;
        bit          seen;

        vecs[0] = '{1'b0, 50, 1'b1, 52};  // directed: src=i, acc_dout=j
        vecs[1] = '{1'b1, 50, 1'b0, 52};  // polynomial B
        vecs[2] = '{1'b0,  1, 1'b0,  5};  // done already high in ARM
        vecs[3] = '{1'b1,  3, 1'b0,  5};  // done on first WAIT cycle
        vecs[4] = '{1'b0,  4, 1'b0,  6};  // done one cycle into WAIT

        rdv[0] = '{0, 0};
        rdv[1] = '{1, 2};
        rdv[2] = '{2, 1};
        rdv[3] = '{3, 3};
        rdv[4] = '{5, 6};
        rdv[5] = '{6, 5};
        rdv[6] = '{128, 128};
        rdv[7] = '{254, 253};
        rdv[8] = '{255, 255};

        reset     = 1'b1;
        wr_en     = 1'b0;
        wr_addr   = 8'd0;
        wr_data   = 12'd0;
        rd_addr   = 8'd0;
        cmd_valid = 1'b0;
        cmd_sel   = 1'b0;
        repeat (3) tick();

        // Reset state
        check("rst_cmd_ready", int'(cmd_ready), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_pulses", int'({load_a_f, load_b_f, start_fntt, start_ab, read_a, read_b, seq_done}), 0);
        check("rst_err", int'(err), 0);
        check("rst_acc_din", int'(acc_din), 0);
        check("rst_rd_data", int'(rd_data), 0);
        reset = 1'b0;
        tick();

        // Table-driven sequences
        for (int v = 0; v < 5; v++) begin
            string tag;
            tag = $sformatf("vec%0d", v);
            fill_src(vecs[v].directed);
            fill_acc(vecs[v].directed);
            done_dly = vecs[v].dly;
            issue(vecs[v].sel, tag);
            wait_done(tag);
            finish_run(vecs[v].sel, vecs[v].rd_off, tag);
            if (v == 0) begin
                for (int r = 0; r < 9; r++) begin
                    rd_addr = 8'(rdv[r].addr);
                    tick();
                    check($sformatf("vec0_res[%0d]", rdv[r].addr), int'(rd_data), rdv[r].exp);
                end
            end
        end

        // Command and write while busy: ignored, stream unaffected
        fill_acc(1'b0);
        done_dly = 50;
        issue(1'b0, "busy");
        repeat (3) tick();  // stream sample 2 is on acc_din
        cmd_valid = 1'b1;
        cmd_sel   = 1'b1;
        wr_en     = 1'b1;
        wr_addr   = 8'd5;
        wr_data   = 12'hABC;
        check("busy_cmd_ready", int'(cmd_ready), 0);
        check("busy_busy", int'(busy), 1);
        tick();
        cmd_valid = 1'b0;
        wr_en     = 1'b0;
        wait_done("busy");
        finish_run(1'b0, 52, "busy");
        repeat (4) tick();
        check("busy_no_queued_cmd", int'(busy), 0);
        check("busy_no_queued_load", n_load_a + n_load_b, 1);

        // Read-first during CAPTURE, and src[5] kept (checked by the stream)
        fill_acc(1'b0);
        old5        = res_model[5];
        acc_vals[6] = ~old5;
        done_dly    = 50;
        issue(1'b1, "rdfirst");
        seen = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            tick();
            if (read_b) begin
                seen = 1'b1;
                break;
            end
        end
        check("rdfirst_read_seen", int'(seen), 1);
        repeat (READ_GAP + 1 + 6) tick();  // capture sample 6 -> index 5
        rd_addr = 8'd5;
        tick();
        check("rdfirst_old_value", int'(rd_data), int'(old5));
        wait_done("rdfirst");
        finish_run(1'b1, 52, "rdfirst");

        // Reset at stream sample 100
        fill_src(1'b0);
        done_dly = 50;
        issue(1'b0, "rstmid");
        repeat (101) tick();
        check("rstmid_din_before", int'(acc_din), int'(src_model[100]));
        reset = 1'b1;
        tick();
        check("rstmid_pulses", int'({load_a_f, load_b_f, start_fntt, start_ab, read_a, read_b, seq_done}), 0);
        check("rstmid_acc_din", int'(acc_din), 0);
        check("rstmid_busy", int'(busy), 0);
        check("rstmid_cmd_ready", int'(cmd_ready), 1);
        reset = 1'b0;
        run_id++;
        repeat (300) tick();
        check("rstmid_no_done", n_done, 0);
        check("rstmid_no_start", n_start, 0);
        fill_acc(1'b0);
        issue(1'b1, "rstnew");
        wait_done("rstnew");
        finish_run(1'b1, 52, "rstnew");

`ifdef KYBER_SEQ_TIMEOUT_EN
        // Watchdog: acc_done never rises
        done_dly = 0;
        issue(1'b0, "tmo");
        wait_done("tmo");
        tick();
        tick();
        check("tmo_done_ofs", cyc_done - cyc_start, 3 + TMO);
        check("tmo_err", int'(err), 1);
        check("tmo_no_read", n_read_a + n_read_b, 0);
        check("tmo_done_cnt", n_done, 1);
        readback_all("tmo_result_kept");
        check("tmo_err_sticky", int'(err), 1);
        fill_acc(1'b0);
        done_dly = 50;
        issue(1'b1, "tmoclr");
        check("tmoclr_err_cleared", int'(err), 0);
        wait_done("tmoclr");
        finish_run(1'b1, 52, "tmoclr");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
